// File: rtl/line_tx.sv
// Byte-wide serial transmitter: one-deep holding register feeding a start/data/parity/stop
// shift stage advanced by an external bit-rate enable.
module line_tx #(
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_clk_tx,
  input  logic [7:0] i_data,
  input  logic [1:0] i_verify_mode,
  input  logic       i_wr_n,
  input  logic       i_ce_n,
  input  logic       i_clear_int_n,
  output logic       o_tx_data,
  output logic       o_busy,
  output logic       o_tx_int,
  output logic       o_err
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  logic [2:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       par_en_q, par_en_d;
  logic       par_odd_q, par_odd_d;
  logic [7:0] hold_data_q, hold_data_d;
  logic [1:0] hold_mode_q, hold_mode_d;
  logic       hold_valid_q, hold_valid_d;
  logic       tx_q, tx_d;
  logic       tx_int_q, tx_int_d;
  logic       err_q, err_d;

  logic active, tick, load, set_int, set_err;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    stop_cnt_d   = stop_cnt_q;
    shift_d      = shift_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    hold_data_d  = hold_data_q;
    hold_mode_d  = hold_mode_q;
    hold_valid_d = hold_valid_q;
    tx_d         = tx_q;
    tx_int_d     = tx_int_q;
    err_d        = err_q;
    load         = 1'b0;
    set_int      = 1'b0;
    set_err      = 1'b0;
    active       = ~i_ce_n;
    tick         = i_clk_tx & active;

    case (state_q)
      ST_IDLE: begin
        if (hold_valid_q && active) begin
          load    = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d  = 3'd0;
            stop_cnt_d = 1'b0;
            state_d    = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          state_d    = ST_STOP;
          stop_cnt_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            set_int    = 1'b1;
            stop_cnt_d = 1'b0;
            if (hold_valid_q) begin
              load    = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      shift_d      = hold_data_q;
      par_en_d     = ~hold_mode_q[1];
      par_odd_d    = hold_mode_q[0];
      hold_valid_d = 1'b0;
    end

    // A write in the same cycle as a load refills the slot the load just vacated.
    if (!i_wr_n && active) begin
      if (!hold_valid_q || load) begin
        hold_data_d  = i_data;
        hold_mode_d  = i_verify_mode;
        hold_valid_d = 1'b1;
      end else begin
        set_err = 1'b1;
      end
    end

    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[bit_cnt_d];
      ST_PARITY: tx_d = par_odd_d ? ~^shift_d : ^shift_d;
      default:   tx_d = 1'b1;
    endcase

    if (set_int)             tx_int_d = 1'b1;
    else if (!i_clear_int_n) tx_int_d = 1'b0;
    if (set_err)             err_d    = 1'b1;
    else if (!i_clear_int_n) err_d    = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      stop_cnt_q   <= 1'b0;
      shift_q      <= '0;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      hold_data_q  <= '0;
      hold_mode_q  <= '0;
      hold_valid_q <= 1'b0;
      tx_q         <= 1'b1;
      tx_int_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      stop_cnt_q   <= stop_cnt_d;
      shift_q      <= shift_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      hold_data_q  <= hold_data_d;
      hold_mode_q  <= hold_mode_d;
      hold_valid_q <= hold_valid_d;
      tx_q         <= tx_d;
      tx_int_q     <= tx_int_d;
      err_q        <= err_d;
    end
  end

  assign o_tx_data = tx_q;
  assign o_busy    = hold_valid_q;
  assign o_tx_int  = tx_int_q;
  assign o_err     = err_q;

endmodule
